// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/register-memory controller: op encodings,
// FSM state type and default widths.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_RD_A = 3'd1;
    localparam state_t S_RD_B = 3'd2;
    localparam state_t S_EXEC = 3'd3;
    localparam state_t S_WB   = 3'd4;

endpackage

// File: rtl/alu32.sv
// Combinational ALU: AND/OR/ADD/SUB/unsigned SLT/NOR; any other op yields
// zero and raises invalid.
module alu32
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] r,
    output logic              invalid
);

    always_comb begin
        r       = '0;
        invalid = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_NOR:  r = ~(a | b);
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mem_ctrl.sv
// Five-state controller: reads two operands from a synchronous register
// memory, runs them through alu32 and writes the result back.
module alu_mem_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
    logic              inv_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] a_q;

    logic [DATA_W-1:0] alu_r;
    logic              alu_inv;
    logic              accept;
    logic              ctrl_we;
    logic              host_ok;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, and the command
    // fields are captured on that edge and not looked at again.
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign host_ok   = host_we & (state == S_IDLE) & ~accept;
    assign ctrl_we   = (state == S_WB) & ~inv_q & (rd_q != '0);
    assign rd_addr   = (state == S_RD_B) ? rb_q : ra_q;
    assign dbg_data  = (dbg_addr == '0) ? '0 : mem[dbg_addr];

    alu32 #(.DATA_W(DATA_W)) u_alu (
        .a       (a_q),
        .b       (rd_data),
        .op      (op_q),
        .r       (alu_r),
        .invalid (alu_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            inv_q  <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= (state == S_WB);
            err  <= (state == S_WB) & inv_q;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_RD_A;
                        op_q  <= cmd_op;
                        ra_q  <= cmd_ra;
                        rb_q  <= cmd_rb;
                        rd_q  <= cmd_rd;
                    end
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: state <= S_EXEC;
                S_EXEC: begin
                    state  <= S_WB;
                    result <= alu_r;
                    zero   <= (alu_r == '0);
                    inv_q  <= alu_inv;
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; entry 0 is masked on every read path.
    always_ff @(posedge clk) begin
        if (ctrl_we)
            mem[rd_q] <= result;
        else if (host_ok && host_waddr != '0)
            mem[host_waddr] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        rd_data <= (rd_addr == '0) ? '0 : mem[rd_addr];
        if (state == S_RD_B)
            a_q <= rd_data;
    end

endmodule

// File: tb/tb_alu_mem_ctrl.sv
// Directed-vector bench for alu_mem_ctrl: preloads memory through the host
// port, runs commands and checks results, flags, latency and memory contents.
module tb_alu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_ra, cmd_rb, cmd_rd;
    logic        host_we;
    logic [3:0]  host_waddr;
    logic [31:0] host_wdata;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] result;
    logic        zero;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    alu_mem_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_rd     (cmd_rd),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .result     (result),
        .zero       (zero),
        .done       (done),
        .err        (err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_cmd(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rd);
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_valid = 1'b1;
    endtask

    task automatic scramble_cmd();
        cmd_op = 3'($urandom_range(0, 7));
        cmd_ra = 4'($urandom_range(0, 15));
        cmd_rb = 4'($urandom_range(0, 15));
        cmd_rd = 4'($urandom_range(0, 15));
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
        host_we    = 1'b1;
        host_waddr = addr;
        host_wdata = data;
        @(negedge clk);
        host_we    = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_outputs(input string tag, input logic exp_err);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, "_res"}, result, e);
        check({tag, "_zero"}, 32'(zero), 32'(e == 32'h0));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rd,
                           input logic [31:0] exp_res, input logic exp_err);
        exp_q.push_back(exp_res);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        drive_cmd(op, ra, rb, rd);
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble_cmd();
        wait_done(tag, 4);
        check_outputs(tag, exp_err);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_ra     = '0;
        cmd_rb     = '0;
        cmd_rd     = '0;
        host_we    = 1'b0;
        host_waddr = '0;
        host_wdata = '0;
        dbg_addr   = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // host preload, including a discarded write to entry 0
        host_write(4'd1, 32'h0000_0005);
        check_mem("host_wr1", 4'd1, 32'h0000_0005);
        host_write(4'd2, 32'h0000_0003);
        host_write(4'd0, 32'hDEAD_BEEF);
        check_mem("host_wr0", 4'd0, 32'h0);

        run_cmd("add", 3'b010, 4'd1, 4'd2, 4'd3, 32'h0000_0008, 1'b0);
        check_mem("add_mem3", 4'd3, 32'h0000_0008);

        // all three addresses equal: operands read before writeback
        run_cmd("add_self", 3'b010, 4'd3, 4'd3, 4'd3, 32'h0000_0010, 1'b0);
        check_mem("add_self_mem3", 4'd3, 32'h0000_0010);

        host_write(4'd1, 32'h0);
        host_write(4'd2, 32'h1);
        run_cmd("sub", 3'b011, 4'd1, 4'd2, 4'd4, 32'hFFFF_FFFF, 1'b0);
        check_mem("sub_mem4", 4'd4, 32'hFFFF_FFFF);
        run_cmd("slt_lt", 3'b100, 4'd1, 4'd2, 4'd5, 32'h0000_0001, 1'b0);
        check_mem("slt_mem5", 4'd5, 32'h0000_0001);
        host_write(4'd8, 32'h0000_0055);
        run_cmd("slt_uns", 3'b100, 4'd4, 4'd2, 4'd8, 32'h0, 1'b0);
        check_mem("slt_mem8", 4'd8, 32'h0);

        run_cmd("nor0", 3'b101, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b0);
        check_mem("nor_mem0", 4'd0, 32'h0);

        host_write(4'd6, 32'h0000_A5A5);
        run_cmd("inv", 3'b111, 4'd1, 4'd2, 4'd6, 32'h0, 1'b1);
        check("inv_done", 32'(done), 32'd1);
        check_mem("inv_mem6", 4'd6, 32'h0000_A5A5);
        @(negedge clk);
        check("inv_done_drop", 32'(done), 32'd0);
        check("inv_err_drop", 32'(err), 32'd0);

        // back-to-back with cmd_valid held; host write attempted in RD_B
        host_write(4'd9, 32'h0000_F0F0);
        host_write(4'd10, 32'h0000_0FF0);
        host_write(4'd13, 32'h0000_0011);
        exp_q.push_back(32'h0000_00F0);
        exp_q.push_back(32'h0000_FFF0);
        drive_cmd(3'b000, 4'd9, 4'd10, 4'd11);
        @(negedge clk);
        drive_cmd(3'b001, 4'd9, 4'd10, 4'd12);
        @(negedge clk);
        host_we    = 1'b1;
        host_waddr = 4'd13;
        host_wdata = 32'h0000_0077;
        @(negedge clk);
        host_we = 1'b0;
        wait_done("b2b_first", 2);
        check_outputs("b2b_first", 1'b0);
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_accepted", 32'(cmd_ready), 32'd0);
        wait_done("b2b_second", 4);
        check_outputs("b2b_second", 1'b0);
        check_mem("b2b_mem11", 4'd11, 32'h0000_00F0);
        check_mem("b2b_mem12", 4'd12, 32'h0000_FFF0);
        check_mem("b2b_mem13", 4'd13, 32'h0000_0011);

        // reset during EXEC aborts the command
        host_write(4'd7, 32'h0000_1234);
        drive_cmd(3'b010, 4'd1, 4'd2, 4'd7);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        check_mem("mid_rst_mem7", 4'd7, 32'h0000_1234);
        check_mem("mid_rst_mem3_kept", 4'd3, 32'h0000_0010);

        run_cmd("post_rst_add", 3'b010, 4'd1, 4'd2, 4'd7, 32'h0000_0001, 1'b0);
        check_mem("post_rst_mem7", 4'd7, 32'h0000_0001);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
